// File: rtl/branch_pred_sequencer.sv
// Gshare predict/update sequencer: one table read-modify-write per decoded SPI record,
// owning the counter-table port, the global history register and prediction statistics.
module branch_pred_sequencer #(
    parameter int ADDR_BITS = 16,
    parameter int IDX_BITS  = 6,
    parameter int GHR_BITS  = 6,
    parameter int CNT_BITS  = 2,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_input_done,
    input  logic [ADDR_BITS-1:0] inst_addr,
    input  logic                 direction_ground_truth,
    output logic                 tbl_rd_en,
    output logic [IDX_BITS-1:0]  tbl_addr,
    input  logic [CNT_BITS-1:0]  tbl_rd_data,
    input  logic                 tbl_rd_valid,
    output logic                 tbl_wr_en,
    output logic [CNT_BITS-1:0]  tbl_wr_data,
    output logic                 prediction,
    output logic                 prediction_valid,
    output logic                 mispredict,
    output logic                 busy,
    output logic                 overrun,
    output logic [GHR_BITS-1:0]  ghr,
    output logic [STAT_BITS-1:0] num_branches,
    output logic [STAT_BITS-1:0] num_mispredicts
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_REQ  = 2'd1,
        READ_WAIT = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   truth_r;
    logic   rd_en_next_s;
    logic   wr_en_next_s;
    logic   busy_next_s;
    logic   accept_s;

    function automatic logic [CNT_BITS-1:0] ctr_step(input logic [CNT_BITS-1:0] ctr,
                                                      input logic taken);
        logic [CNT_BITS-1:0] res;
        if (taken) begin
            res = (&ctr) ? ctr : ctr + CNT_BITS'(1);
        end else begin
            res = (ctr == {CNT_BITS{1'b0}}) ? ctr : ctr - CNT_BITS'(1);
        end
        return res;
    endfunction

    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] val);
        return (&val) ? val : val + STAT_BITS'(1);
    endfunction

    // Only the index bits of the address feed the hash.
    if (ADDR_BITS > IDX_BITS) begin : g_addr_hi
        logic unused_addr_hi_s;
        assign unused_addr_hi_s = ^inst_addr[ADDR_BITS-1:IDX_BITS];
    end

    assign accept_s = (state_r == IDLE) && data_input_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; the READ_WAIT hold has no timeout by design.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_input_done) begin
                    state_next_s = READ_REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ_REQ: state_next_s = READ_WAIT;
            READ_WAIT: begin
                if (tbl_rd_valid) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = READ_WAIT;
                end
            end
            UPDATE:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Strobe decode from the upcoming state so the registered strobes align with it.
    always_comb begin
        rd_en_next_s = 1'b0;
        wr_en_next_s = 1'b0;
        busy_next_s  = 1'b1;
        case (state_next_s)
            IDLE:      busy_next_s  = 1'b0;
            READ_REQ:  rd_en_next_s = 1'b1;
            READ_WAIT: busy_next_s  = 1'b1;
            UPDATE:    wr_en_next_s = 1'b1;
            default:   busy_next_s  = 1'b0;
        endcase
    end

    // Registered outputs, transaction datapath, history and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_rd_en        <= 1'b0;
            tbl_wr_en        <= 1'b0;
            prediction_valid <= 1'b0;
            busy             <= 1'b0;
            tbl_addr         <= {IDX_BITS{1'b0}};
            tbl_wr_data      <= {CNT_BITS{1'b0}};
            truth_r          <= 1'b0;
            prediction       <= 1'b0;
            mispredict       <= 1'b0;
            overrun          <= 1'b0;
            ghr              <= {GHR_BITS{1'b0}};
            num_branches     <= {STAT_BITS{1'b0}};
            num_mispredicts  <= {STAT_BITS{1'b0}};
        end else begin
            tbl_rd_en        <= rd_en_next_s;
            tbl_wr_en        <= wr_en_next_s;
            prediction_valid <= wr_en_next_s;
            busy             <= busy_next_s;
            if (accept_s) begin
                tbl_addr <= inst_addr[IDX_BITS-1:0] ^ IDX_BITS'(ghr);
                truth_r  <= direction_ground_truth;
            end else if (data_input_done) begin
                overrun <= 1'b1;
            end
            if ((state_r == READ_WAIT) && tbl_rd_valid) begin
                prediction  <= tbl_rd_data[CNT_BITS-1];
                mispredict  <= tbl_rd_data[CNT_BITS-1] ^ truth_r;
                tbl_wr_data <= ctr_step(tbl_rd_data, truth_r);
            end
            if (state_r == UPDATE) begin
                // Truncating cast keeps the youngest GHR_BITS outcomes, including GHR_BITS=1.
                ghr          <= GHR_BITS'({ghr, truth_r});
                num_branches <= stat_inc(num_branches);
                if (mispredict) begin
                    num_mispredicts <= stat_inc(num_mispredicts);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_sequencer.sv
// Randomized bench for branch_pred_sequencer: a behavioural gshare model plus table memory
// drives two instances (16-bit and 2-bit statistics) and checks every transaction.
module tb_branch_pred_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_input_done;
    logic [15:0] inst_addr;
    logic        direction_ground_truth;
    logic [1:0]  tbl_rd_data;
    logic        tbl_rd_valid;

    logic        tbl_rd_en, tbl_wr_en, prediction, prediction_valid, mispredict, busy, overrun;
    logic [5:0]  tbl_addr, ghr;
    logic [1:0]  tbl_wr_data;
    logic [15:0] num_branches, num_mispredicts;

    logic        s2_prediction_valid, s2_overrun;
    logic [1:0]  s2_tbl_wr_data, s2_num_branches, s2_num_mispredicts;
    logic        unused2_rd_en, unused2_wr_en, unused2_pred, unused2_mis, unused2_busy;
    logic [5:0]  unused2_addr, unused2_ghr;

    int n_checks = 0;
    int n_pass   = 0;

    int mem [64];
    int m_ghr, m_nb, m_nm;
    bit m_ovr;

    always #5 clk = ~clk;

    branch_pred_sequencer dut (
        .clk(clk), .rst(rst), .data_input_done(data_input_done), .inst_addr(inst_addr),
        .direction_ground_truth(direction_ground_truth), .tbl_rd_en(tbl_rd_en),
        .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data), .tbl_rd_valid(tbl_rd_valid),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_data(tbl_wr_data), .prediction(prediction),
        .prediction_valid(prediction_valid), .mispredict(mispredict), .busy(busy),
        .overrun(overrun), .ghr(ghr), .num_branches(num_branches),
        .num_mispredicts(num_mispredicts)
    );

    branch_pred_sequencer #(.STAT_BITS(2)) dut_s2 (
        .clk(clk), .rst(rst), .data_input_done(data_input_done), .inst_addr(inst_addr),
        .direction_ground_truth(direction_ground_truth), .tbl_rd_en(unused2_rd_en),
        .tbl_addr(unused2_addr), .tbl_rd_data(tbl_rd_data), .tbl_rd_valid(tbl_rd_valid),
        .tbl_wr_en(unused2_wr_en), .tbl_wr_data(s2_tbl_wr_data), .prediction(unused2_pred),
        .prediction_valid(s2_prediction_valid), .mispredict(unused2_mis), .busy(unused2_busy),
        .overrun(s2_overrun), .ghr(unused2_ghr), .num_branches(s2_num_branches),
        .num_mispredicts(s2_num_mispredicts)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ghr = 0;
        m_nb  = 0;
        m_nm  = 0;
        m_ovr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {tbl_rd_en, tbl_wr_en, prediction, prediction_valid, mispredict, busy,
                        overrun, tbl_addr, ghr, tbl_wr_data, num_branches, num_mispredicts}, 0);
        check_val({tag, "_s2"}, {s2_prediction_valid, s2_overrun, s2_tbl_wr_data,
                                 s2_num_branches, s2_num_mispredicts}, 0);
    endtask

    // Called at a negedge; a pulse asserted here is sampled by the next rising edge.
    task automatic do_reset();
        rst = 1'b1;
        data_input_done = 1'b1;
        inst_addr = 16'h00ff;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        data_input_done = 1'b0;
        @(negedge clk);
        model_reset();
        check_all_zero("reset");
    endtask

    // One transaction starting at a negedge; returns at the negedge where the DUT is IDLE again.
    task automatic run_txn(input int addr, input int truth, input int lat,
                           input bit inject_ovr, input bit rst_mid);
        int idx, ctr, exp_wr;
        bit pred, mis;
        idx    = (addr ^ m_ghr) % 64;
        ctr    = mem[idx];
        pred   = (ctr >= 2);
        mis    = (pred != (truth != 0));
        exp_wr = (truth != 0) ? ((ctr == 3) ? 3 : ctr + 1) : ((ctr == 0) ? 0 : ctr - 1);

        data_input_done = 1'b1;
        inst_addr = addr[15:0];
        direction_ground_truth = truth[0];
        @(negedge clk);
        data_input_done = 1'b0;
        inst_addr = 16'($urandom);
        direction_ground_truth = 1'($urandom);
        check_val("req_rd_en", tbl_rd_en, 1);
        check_val("req_addr", tbl_addr, idx);
        check_val("req_busy", busy, 1);
        if (inject_ovr) begin
            data_input_done = 1'b1;
            m_ovr = 1'b1;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            data_input_done = 1'b0;
            check_val("wait_rd_en", tbl_rd_en, 0);
            check_val("wait_wr_en", {tbl_wr_en, prediction_valid}, 0);
            check_val("wait_addr", tbl_addr, idx);
            check_val("wait_busy", busy, 1);
            if (k == lat) begin
                if (rst_mid) begin
                    rst = 1'b1;
                end else begin
                    tbl_rd_valid = 1'b1;
                    tbl_rd_data  = 2'(ctr);
                end
            end
        end
        @(negedge clk);
        tbl_rd_valid = 1'b0;
        tbl_rd_data  = 2'($urandom);
        if (rst_mid) begin
            rst = 1'b0;
            model_reset();
            check_all_zero("rst_mid");
            return;
        end
        check_val("upd_strobes", {tbl_wr_en, prediction_valid, tbl_rd_en}, 3'b110);
        check_val("upd_wr_data", tbl_wr_data, exp_wr);
        check_val("upd_pred", {prediction, mispredict}, {pred, mis});
        check_val("upd_addr", tbl_addr, idx);
        check_val("upd_ghr_old", ghr, m_ghr);
        check_val("upd_s2", {s2_prediction_valid, s2_tbl_wr_data}, {1'b1, 2'(exp_wr)});
        mem[idx] = exp_wr;
        m_ghr = ((m_ghr << 1) | (truth != 0 ? 1 : 0)) % 64;
        m_nb  = (m_nb < 65535) ? m_nb + 1 : m_nb;
        if (mis) m_nm = (m_nm < 65535) ? m_nm + 1 : m_nm;
        @(negedge clk);
        check_val("idle_strobes", {tbl_wr_en, prediction_valid, busy, tbl_rd_en}, 0);
        check_val("idle_ghr", ghr, m_ghr);
        check_val("idle_nb", num_branches, m_nb);
        check_val("idle_nm", num_mispredicts, m_nm);
        check_val("idle_held", {prediction, mispredict}, {pred, mis});
        check_val("idle_overrun", {overrun, s2_overrun}, {m_ovr, m_ovr});
        check_val("idle_s2_nb", s2_num_branches, (m_nb > 3) ? 3 : m_nb);
        check_val("idle_s2_nm", s2_num_mispredicts, (m_nm > 3) ? 3 : m_nm);
    endtask

    initial begin
        rst = 1'b1;
        data_input_done = 1'b0;
        inst_addr = 16'h0000;
        direction_ground_truth = 1'b0;
        tbl_rd_data = 2'b00;
        tbl_rd_valid = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = int'($urandom_range(0, 3));
        model_reset();
        @(negedge clk);
        do_reset();

        // Directed: weakly not-taken miss, saturate at taken, saturate at not-taken.
        mem[6'h34] = 1;
        run_txn(16'h1234, 1, 1, 1'b0, 1'b0);
        check_val("t1_ghr", ghr, 6'b000001);
        mem[6'h35] = 3;
        run_txn(16'h1234, 1, 1, 1'b0, 1'b0);
        check_val("t2_stats", {num_branches, num_mispredicts}, {16'd2, 16'd1});
        mem[(16'h0010 ^ 3) % 64] = 0;
        run_txn(16'h0010, 0, 1, 1'b0, 1'b0);
        check_val("t3_ghr", ghr, 6'b000110);

        // Dropped pulse, slow table, and reset during READ_WAIT.
        run_txn(int'($urandom_range(0, 65535)), 1, 1, 1'b1, 1'b0);
        run_txn(int'($urandom_range(0, 65535)), 0, 6, 1'b0, 1'b0);
        run_txn(int'($urandom_range(0, 65535)), 1, 5, 1'b0, 1'b1);

        // Random traffic; 2-bit statistics instance saturates along the way.
        for (int t = 0; t < 60; t++) begin
            run_txn(int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
                    int'($urandom_range(1, 4)), ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_pred_sequencer.md
Name: branch_pred_sequencer

Overview:
- Sequences one gshare predict/update transaction per decoded SPI record.
- Accepts the SPI receiver's one-cycle done pulse together with the instruction address and the ground-truth direction.
- Owns the pattern-history-table port and the global history register (GHR), and keeps prediction statistics.
- Sits between the SPI receiver and the counter-table memory. It is the only master of that table.

Parameters:
ADDR_BITS, 16, width of the latched instruction address
IDX_BITS, 6, table index width (table depth 2^IDX_BITS)
GHR_BITS, 6, global history length; must satisfy 1 <= GHR_BITS <= IDX_BITS
CNT_BITS, 2, saturating-counter width stored per table entry
STAT_BITS, 16, width of each statistics counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
data_input_done  in  1  one-cycle pulse: inst_addr and direction_ground_truth are valid
inst_addr  in  ADDR_BITS  branch instruction address
direction_ground_truth  in  1  actual outcome, 1 = taken
tbl_rd_en  out  1  table read request, one cycle
tbl_addr  out  IDX_BITS  table index for both the read and the write
tbl_rd_data  in  CNT_BITS  counter value returned by the table
tbl_rd_valid  in  1  tbl_rd_data valid; read latency >= 1 cycle
tbl_wr_en  out  1  table write strobe, one cycle
tbl_wr_data  out  CNT_BITS  updated counter value
prediction  out  1  predicted direction, held until the next transaction
prediction_valid  out  1  one-cycle pulse when prediction and mispredict update
mispredict  out  1  prediction != ground truth, held
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a done pulse arrived while busy
ghr  out  GHR_BITS  current global history
num_branches  out  STAT_BITS  saturating count of completed transactions
num_mispredicts  out  STAT_BITS  saturating count of mispredictions

Behaviour:
- Reset value of every output and internal register is 0; the FSM returns to IDLE.
- Reset mid-transaction aborts it with no table write. Table contents are not touched by reset.
- FSM states: IDLE, READ_REQ, READ_WAIT, UPDATE.
- IDLE:
  - On data_input_done=1, register inst_addr and direction_ground_truth.
  - Compute idx = inst_addr[IDX_BITS-1:0] XOR zero-extended ghr and register it on tbl_addr.
  - Go to READ_REQ.
- READ_REQ:
  - tbl_rd_en=1 for exactly this cycle. tbl_rd_valid is ignored here.
  - Go to READ_WAIT.
- READ_WAIT:
  - Stay until tbl_rd_valid=1. There is no timeout.
  - On valid, register ctr = tbl_rd_data.
  - Register prediction = ctr[CNT_BITS-1] and mispredict = (prediction != truth).
  - Go to UPDATE.
- UPDATE (exactly one cycle):
  - tbl_wr_en=1 and prediction_valid=1.
  - tbl_wr_data = ctr+1 if truth=1, ctr-1 if truth=0, saturating at all-ones and at 0.
  - On exit:
    - ghr <= {ghr[GHR_BITS-2:0], truth}; for GHR_BITS=1, ghr <= truth.
    - num_branches increments, saturating at all-ones.
    - num_mispredicts increments if mispredict, saturating at all-ones.
  - Go to IDLE.
- tbl_addr is held constant from READ_REQ through UPDATE.
- Latency with 1-cycle table read latency (T = edge sampling the pulse):
  - READ_REQ at T+1, READ_WAIT at T+2, UPDATE at T+3, IDLE at T+4.
  - A back-to-back pulse is accepted at T+4.
- A data_input_done pulse in any non-IDLE state is dropped: overrun <= 1, no other effect. overrun clears only on reset.
- A pulse in the same cycle as rst is ignored.
- Stats and ghr change only on UPDATE exit.

Test Plan:
1. Reset; pulse with inst_addr=0x1234, truth=1; table returns 2'b01 one cycle after rd_en -> tbl_addr=0x34, prediction=0, mispredict=1, tbl_wr_data=2'b10, num_branches=1, num_mispredicts=1, ghr=6'b000001, prediction_valid high exactly at T+3.
2. Continue from 1: inst_addr=0x1234, truth=1, table returns 2'b11 -> tbl_addr=0x35, prediction=1, mispredict=0, tbl_wr_data=2'b11 (saturated), num_branches=2, num_mispredicts=1, ghr=6'b000011.
3. Counter 2'b00 with truth=0 -> tbl_wr_data=2'b00, prediction=0, mispredict=0; ghr shifts in 0.
4. Second pulse at T+2 of an active transaction -> overrun=1, pulse ignored, first transaction completes normally, num_branches increments by 1 only.
5. tbl_rd_valid delayed 5 cycles -> FSM holds READ_WAIT and tbl_addr stable, tbl_rd_en high for exactly one cycle. Repeat, asserting rst during READ_WAIT -> no tbl_wr_en, all outputs 0, FSM in IDLE.
6. STAT_BITS=2, 5 mispredicted transactions -> num_branches=3 and num_mispredicts=3 (saturated, no wrap).
